bram_read_arbiter: RTL
======================

// Module: bram_read_arbiter
// PURPOSE
//  Shares one synchronous BRAM read port among NUM_REQ requesters. This replaces the
//  hard-coded done-flag address muxes, e.g. image_processing vs VGA on the frame buffer.
//  Each cycle it grants at most one request and drives the BRAM address.
//  It then returns the BRAM data with a one-hot valid tag to the winning requester.
//  Arbitration is fixed-priority with starvation promotion, or round-robin.
// PARAMETERS
//  NUM_REQ       4   number of requesters (2..8)
//  ADDR_WIDTH    19  BRAM address width
//  DATA_WIDTH    12  BRAM data width
//  READ_LATENCY  2   cycles from bram_addr valid to bram_dout valid (1..4)
//  MODE          0   0 = fixed priority (index 0 highest), 1 = round-robin
//  STARVE_LIMIT  15  MODE 0 only: wait cycles before a waiting requester is promoted (1..255)
// PORTS
//  clk_25mhz  in   1                    single clock; all state on rising edge
//  reset      in   1                    synchronous, active-high
//  req        in   NUM_REQ              per-requester read request; level, held until granted
//  req_addr   in   NUM_REQ*ADDR_WIDTH   flattened addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//  gnt        out  NUM_REQ              one-hot combinational grant; request accepted on edge where req[i]&gnt[i]
//  bram_addr  out  ADDR_WIDTH           registered BRAM read address
//  bram_dout  in   DATA_WIDTH           BRAM read data
//  rd_valid   out  NUM_REQ              one-hot: rd_data belongs to requester i this cycle
//  rd_data    out  DATA_WIDTH           bram_dout passthrough; qualify with rd_valid
//  busy       out  1                    any read in flight (OR of valid pipeline)
// BEHAVIOUR
//  - Reset (sync, overrides all):
//    - gnt=0 while reset is high; bram_addr=0; rd_valid=0; busy=0.
//    - The valid pipeline is cleared, so in-flight reads are dropped with no rd_valid.
//    - RR pointer resets to NUM_REQ-1, so requester 0 wins first. Starve counters reset to 0.
//  - Grant (combinational, from req and registered state):
//    - gnt is zero when req==0, otherwise exactly one bit.
//    - gnt[i] is never high unless req[i] is high.
//  - MODE 1:
//    - Search order is ptr+1, ptr+2, ... modulo NUM_REQ; first requesting index wins.
//    - On an accepted grant, ptr <= winner. ptr is unchanged on idle cycles.
//  - MODE 0:
//    - If any requester has starve_cnt == STARVE_LIMIT, the lowest such index wins.
//    - Otherwise the lowest requesting index wins.
//    - starve_cnt[i]: +1 per cycle with req[i]&!gnt[i], saturating at STARVE_LIMIT.
//    - starve_cnt[i] clears to 0 when gnt[i] is high or req[i] is low.
//  - Accept edge N (req & gnt != 0):
//    - bram_addr <= addr of the winner, valid during cycle N+1.
//    - Winner one-hot enters a READ_LATENCY-deep valid shift register.
//  - Idle cycle: bram_addr holds its last value; a zero vector enters the pipeline.
//  - Latency:
//    - Accept at edge N gives rd_valid at cycle N+1+READ_LATENCY, with rd_data = bram_dout.
//    - Throughput is one read per cycle. Back-to-back accepts give back-to-back valids.
//    - Returned data stays in issue order.
//  - Requester holding req after an accept issues a new read next cycle. It must update
//    req_addr on the same edge.
//  - req_addr changes while waiting are allowed; the address sampled at the accept edge is used.
//  - No backpressure: consumers must capture rd_data in the rd_valid cycle.
//  - Widths: addresses are passed unmodified with no truncation.
//  - Starve counter width = clog2(STARVE_LIMIT+1).
// TESTING
//  T1 MODE0: req=4'b0110 held ->
//    - gnt=0010 every cycle while req[1] holds (STARVE_LIMIT=255).
//    - req[2] only wins after req[1] drops.
//  T2 MODE1: req=4'b1111 held 8 cycles -> grant order 0,1,2,3,0,1,2,3. ptr==3 after cycle 4.
//  T3 latency, READ_LATENCY=2: req[2], addr 19'h00123 accepted at edge N ->
//    - bram_addr=0x00123 at N+1.
//    - rd_valid=0100 exactly at N+3 with rd_data=model[0x00123].
//    - rd_valid is 0 in all other cycles.
//  T4 starvation, MODE0, STARVE_LIMIT=8: req[0] continuous, req[3] asserted at cycle 0 ->
//    - gnt=1000 at cycle 8.
//    - gnt returns to 0001 at cycle 9.
//  T5 throughput: req[1] held 16 cycles with incrementing addresses ->
//    - 16 consecutive rd_valid=0010 cycles.
//    - Data matches addresses in order.
//  T6 reset mid-flight: accept at edge N, reset high during N+1 ->
//    - No rd_valid at N+3; busy=0 and bram_addr=0 after reset.
//    - First grant after reset goes to requester 0 (MODE1).

Source files
------------

// File: rtl/bram_read_arbiter.sv
// Shares one synchronous BRAM read port among NUM_REQ requesters and routes the
// returned data back with a one-hot valid tag. Fixed priority with starvation promotion, or round-robin.

module bram_read_arbiter_starve #(
  parameter int SW    = 4,
  parameter int LIMIT = 15
) (
  input  logic          clk_25mhz,
  input  logic          reset,
  input  logic          req,
  input  logic          gnt,
  output logic [SW-1:0] cnt
);
  always_ff @(posedge clk_25mhz) begin
    if (reset || gnt || !req) cnt <= '0;
    else if (cnt != SW'(LIMIT)) cnt <= cnt + 1'b1;
  end
endmodule

module bram_read_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int ADDR_WIDTH   = 19,
  parameter int DATA_WIDTH   = 12,
  parameter int READ_LATENCY = 2,
  parameter int MODE         = 0,
  parameter int STARVE_LIMIT = 15
) (
  input  logic                          clk_25mhz,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [ADDR_WIDTH-1:0]         bram_addr,
  input  logic [DATA_WIDTH-1:0]         bram_dout,
  output logic [NUM_REQ-1:0]            rd_valid,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          busy
);
  localparam int IW     = $clog2(NUM_REQ);
  localparam int SW     = $clog2(STARVE_LIMIT + 1);
  localparam int STAGES = READ_LATENCY;

  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] addr_arr;
  logic [NUM_REQ-1:0][SW-1:0]         starve_cnt;
  logic [NUM_REQ-1:0]                 starved;
  logic [STAGES:0][NUM_REQ-1:0]       vld_pipe;
  logic [IW-1:0]                      ptr, win;
  logic [IW:0]                        sum;
  logic                               found;

  assign addr_arr = req_addr;

  genvar gi;
  generate
    if (MODE == 0) begin : g_fp
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
        bram_read_arbiter_starve #(.SW(SW), .LIMIT(STARVE_LIMIT)) u_starve (
          .clk_25mhz (clk_25mhz),
          .reset     (reset),
          .req       (req[gi]),
          .gnt       (gnt[gi]),
          .cnt       (starve_cnt[gi])
        );
        assign starved[gi] = (starve_cnt[gi] == SW'(STARVE_LIMIT));
      end
    end else begin : g_rr
      assign starve_cnt = '0;
      assign starved    = '0;
    end
  endgenerate

  // Loops run from the lowest-priority candidate up, so the last hit is the winner.
  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    if (MODE == 0) begin
      for (int i = NUM_REQ - 1; i >= 0; i--)
        if (req[i]) begin found = 1'b1; win = IW'(i); end
      for (int i = NUM_REQ - 1; i >= 0; i--)
        if (req[i] && starved[i]) win = IW'(i);
    end else begin
      for (int k = NUM_REQ; k >= 1; k--) begin
        sum = {1'b0, ptr} + (IW+1)'(k);
        if (sum >= (IW+1)'(NUM_REQ)) sum = sum - (IW+1)'(NUM_REQ);
        if (req[sum[IW-1:0]]) begin found = 1'b1; win = sum[IW-1:0]; end
      end
    end
  end

  assign gnt = (found && !reset) ? (NUM_REQ'(1) << win) : '0;

  // vld_pipe[0] lines up with bram_addr; the tag reaches the top when bram_dout is valid.
  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      bram_addr <= '0;
      ptr       <= IW'(NUM_REQ - 1);
      vld_pipe  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], gnt};
      if (found) begin
        bram_addr <= addr_arr[win];
        ptr       <= win;
      end
    end
  end

  assign rd_valid = vld_pipe[STAGES];
  assign rd_data  = bram_dout;
  assign busy     = |vld_pipe;
endmodule
